lab03_cpu_mult_ctrl: RTL and testbench
======================================

LAB03_CPU_MULT_CTRL -- requirements
Module: lab03_cpu_mult_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 1: clock cycles from mult-cell enable to valid partial products (range 1..4).
REQ-002 SHALL have port clk, input, 1: single clock for all logic.
REQ-003 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1: request a new 32x32 multiply.
REQ-005 SHALL have port flush, input, 1: abandon the operation in flight.
REQ-006 SHALL have port src1 and port src2, input, 32 each: operands.
REQ-007 SHALL have port E_src1 and port E_src2, output, 32 each: operands driven to the mult cell.
REQ-008 SHALL have port M_en, output, 1: mult-cell register enable.
REQ-009 SHALL have ports M_mul_cell_p1, M_mul_cell_p2 and M_mul_cell_p3, input, 32 each: partial products lo*lo, lo1*hi2 and hi1*lo2.
REQ-010 SHALL have port busy, output, 1: an operation is in flight.
REQ-011 SHALL have port done, output, 1: single-cycle pulse marking result valid.
REQ-012 SHALL have port result, output, 32: low 32 bits of src1*src2.

Function
REQ-013 SHALL implement the states IDLE, ISSUE, WAIT, SUM and DONE, plus OUT when the configuration macro is defined.
REQ-014 In IDLE with start=1 and flush=0, SHALL latch src1/src2 into E_src1/E_src2 and go to ISSUE.
REQ-015 SHALL ignore start in every state other than IDLE; latched operands SHALL stay stable until the next accept.
REQ-016 ISSUE SHALL last one cycle with M_en=1; M_en SHALL be 0 in all other states.
REQ-017 ISSUE SHALL go to WAIT when MUL_LAT>1, else directly to SUM.
REQ-018 WAIT SHALL last MUL_LAT-1 cycles, counted by a down-counter loaded on leaving ISSUE, then go to SUM.
REQ-019 SUM SHALL register result = (p1 + ((p2 + p3) << 16)) mod 2^32; intermediate carries above bit 31 SHALL be discarded.
REQ-020 SUM SHALL go to DONE; DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-021 Without the macro, done SHALL be asserted exactly MUL_LAT+2 cycles after the accept cycle.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 A back-to-back start presented in the DONE cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.
REQ-024 flush=1 in any state SHALL force IDLE on the next edge with no done pulse; result SHALL hold its last value.
REQ-025 flush and start asserted together in IDLE: flush wins and the start is dropped.

Reset
REQ-026 reset_n=0 sampled at a clk edge SHALL force IDLE, clear the WAIT counter and set busy=0, done=0, M_en=0, result=0, E_src1=0, E_src2=0.
REQ-027 Reset mid-operation SHALL abandon the operation with no done pulse; reset SHALL take priority over flush and start.

Configuration
REQ-028 Macro LAB03_MULT_CTRL_OUTREG_EN SHALL control an output pipeline register.
REQ-029 With LAB03_MULT_CTRL_OUTREG_EN defined, SUM SHALL go to OUT, which registers the sum into result, and OUT SHALL go to DONE; done latency SHALL be MUL_LAT+3 cycles.
REQ-030 With LAB03_MULT_CTRL_OUTREG_EN undefined, the OUT state and its register SHALL be absent and latency SHALL be MUL_LAT+2 cycles.

Structure
REQ-031 Shared package lab03_cpu_mult_pkg SHALL hold the state enum type, the MUL_LAT default constant, the 16-bit half-word width constant and the partial-product combine function.
REQ-032 The block SHALL contain no sub-module; the mult cell is instantiated by the parent, and the bench models it as a MUL_LAT-cycle registered multiplier with clock enable.

Verification
REQ-033 The bench SHALL cover: start with src1=3, src2=5, MUL_LAT=1 -> done in cycle 3 (no macro), result=0x0000000F, busy high for cycles 1..3.
REQ-034 The bench SHALL cover: src1=0xFFFFFFFF, src2=0xFFFFFFFF -> result=0x00000001 (wrap).
REQ-035 The bench SHALL cover: src1=0x12345678, src2=0x00000010, MUL_LAT=3 -> done in cycle 5, result=0x23456780.
REQ-036 The bench SHALL cover: start accepted, then flush asserted in ISSUE -> IDLE next cycle, no done, result unchanged from the previous operation.
REQ-037 The bench SHALL cover: start held high continuously for two operands -> the second is accepted only in the IDLE cycle after DONE, two done pulses, correct results.
REQ-038 The bench SHALL cover: reset_n=0 asserted in WAIT -> all outputs zero on the next edge, no done, next start behaves normally.

Source files
------------

// File: rtl/lab03_cpu_mult_pkg.sv
// lab03_cpu_mult_pkg: shared types, constants and partial-product combine for the multiply controller.
package lab03_cpu_mult_pkg;
  localparam int MUL_LAT_DEF = 1;
  localparam int HALF_W = 16;
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    SUM,
`ifdef LAB03_MULT_CTRL_OUTREG_EN
    OUT,
`endif
    DONE
  } state_e;
  function automatic logic [31:0] mul_combine(input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3);
    logic [31:0] mid;
    mid = p2 + p3;
    return p1 + (mid << HALF_W);
  endfunction
endpackage

// File: rtl/lab03_cpu_mult_ctrl.sv
// lab03_cpu_mult_ctrl: sequences an external 32x32 mult cell and sums its partial products.
// Define LAB03_MULT_CTRL_OUTREG_EN to add an output pipeline stage (OUT state).
module lab03_cpu_mult_ctrl
  import lab03_cpu_mult_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [31:0] E_src1,
  output logic [31:0] E_src2,
  output logic        M_en,
  input  logic [31:0] M_mul_cell_p1,
  input  logic [31:0] M_mul_cell_p2,
  input  logic [31:0] M_mul_cell_p3,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  localparam logic [1:0] CNT_LOAD = MUL_LAT > 1 ? 2'(MUL_LAT - 2) : 2'd0;
  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [31:0] e1_q, e1_d, e2_q, e2_d, res_q, res_d, sum;
  logic accept;
  assign accept = state_q == IDLE && start && !flush;
  assign sum = mul_combine(M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (flush) state_d = IDLE;
    else
      unique case (state_q)
        IDLE: state_d = start ? ISSUE : IDLE;
        ISSUE: begin
          state_d = MUL_LAT > 1 ? WAIT : SUM;
          cnt_d = CNT_LOAD;
        end
        WAIT: begin
          state_d = cnt_q == 2'd0 ? SUM : WAIT;
          cnt_d = cnt_q == 2'd0 ? 2'd0 : cnt_q - 2'd1;
        end
`ifdef LAB03_MULT_CTRL_OUTREG_EN
        SUM: state_d = OUT;
        OUT: state_d = DONE;
`else
        SUM: state_d = DONE;
`endif
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
  end
  assign e1_d = accept ? src1 : e1_q;
  assign e2_d = accept ? src2 : e2_q;
`ifdef LAB03_MULT_CTRL_OUTREG_EN
  logic [31:0] sum_q, sum_d;
  assign sum_d = state_q == SUM && !flush ? sum : sum_q;
  assign res_d = state_q == OUT && !flush ? sum_q : res_q;
  always_ff @(posedge clk)
    if (!reset_n) sum_q <= '0;
    else sum_q <= sum_d;
`else
  assign res_d = state_q == SUM && !flush ? sum : res_q;
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      e1_q <= '0;
      e2_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      e1_q <= e1_d;
      e2_q <= e2_d;
      res_q <= res_d;
    end
  end
  assign E_src1 = e1_q;
  assign E_src2 = e2_q;
  assign M_en = state_q == ISSUE;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign result = res_q;
endmodule

// File: tb/tb_lab03_cpu_mult_ctrl.sv
// tb_lab03_cpu_mult_ctrl: two controllers (MUL_LAT 1 and 3) with registered mult-cell models,
// checked against a plain 64-bit product and a latency/timeline reference.
module tb_lab03_cpu_mult_ctrl;
`ifdef LAB03_MULT_CTRL_OUTREG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n [2];
  logic start [2];
  logic flush [2];
  logic m_en [2];
  logic busy [2];
  logic done [2];
  logic [31:0] src1 [2];
  logic [31:0] src2 [2];
  logic [31:0] e1 [2];
  logic [31:0] e2 [2];
  logic [31:0] p1 [2];
  logic [31:0] p2 [2];
  logic [31:0] p3 [2];
  logic [31:0] result [2];
  int errors = 0;
  int checks = 0;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = g ? 3 : 1;
    logic [31:0] pp [3][4];
    lab03_cpu_mult_ctrl #(.MUL_LAT(L)) dut (
      .clk(clk), .reset_n(reset_n[g]), .start(start[g]), .flush(flush[g]),
      .src1(src1[g]), .src2(src2[g]), .E_src1(e1[g]), .E_src2(e2[g]), .M_en(m_en[g]),
      .M_mul_cell_p1(p1[g]), .M_mul_cell_p2(p2[g]), .M_mul_cell_p3(p3[g]),
      .busy(busy[g]), .done(done[g]), .result(result[g])
    );
    always @(posedge clk) begin
      if (m_en[g]) begin
        pp[0][0] <= {16'b0, e1[g][15:0]} * {16'b0, e2[g][15:0]};
        pp[1][0] <= {16'b0, e1[g][15:0]} * {16'b0, e2[g][31:16]};
        pp[2][0] <= {16'b0, e1[g][31:16]} * {16'b0, e2[g][15:0]};
      end
      for (int s = 1; s < 4; s++)
        for (int j = 0; j < 3; j++) pp[j][s] <= pp[j][s-1];
    end
    assign p1[g] = pp[0][L-1];
    assign p2[g] = pp[1][L-1];
    assign p3[g] = pp[2][L-1];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ctl(input int k);
    return {29'b0, busy[k], done[k], m_en[k]};
  endfunction
  function automatic int lat_of(input int k);
    return (k ? 3 : 1) + 2 + EXTRA;
  endfunction
  function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] full;
    full = {32'b0, a} * {32'b0, b};
    return full[31:0];
  endfunction
  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b);
    int lat;
    lat = lat_of(k);
    start[k] = 1'b1;
    src1[k] = a;
    src2[k] = b;
    @(negedge clk);
    start[k] = 1'b0;
    src1[k] = $urandom;
    src2[k] = $urandom;
    for (int c = 1; c <= lat + 1; c++) begin
      check("ctl", ctl(k), {29'b0, c <= lat, c == lat, c == 1});
      if (c == 1) check("latch", e1[k] ^ e2[k], a ^ b);
      if (c == lat) check("result", result[k], prod(a, b));
      if (c <= lat) @(negedge clk);
    end
  endtask
  initial begin
    logic [31:0] a, b, r;
    int lat;
    for (int k = 0; k < 2; k++) begin
      reset_n[k] = 1'b0;
      start[k] = 1'b0;
      flush[k] = 1'b0;
      src1[k] = $urandom;
      src2[k] = $urandom;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      reset_n[k] = 1'b1;
      check("rst_ctl", ctl(k), 32'd0);
      check("rst_res", result[k], 32'd0);
      check("rst_e1", e1[k], 32'd0);
      check("rst_e2", e2[k], 32'd0);
    end
    run_op(0, 32'd3, 32'd5);
    check("r3x5", result[0], 32'h0000000F);
    run_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("wrap", result[0], 32'h00000001);
    for (int i = 0; i < 6; i++) run_op(0, $urandom, $urandom);
    run_op(0, 32'h0000FFFF, 32'hFFFF0000);
    r = result[0];
    a = e1[0];
    start[0] = 1'b1;
    src1[0] = $urandom;
    src2[0] = $urandom;
    @(negedge clk);
    start[0] = 1'b0;
    check("fl_issue", ctl(0), 32'd5);
    flush[0] = 1'b1;
    @(negedge clk);
    flush[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("fl_idle", ctl(0), 32'd0);
      check("fl_hold", result[0], r);
      @(negedge clk);
    end
    a = e1[0];
    start[0] = 1'b1;
    flush[0] = 1'b1;
    src1[0] = ~a;
    @(negedge clk);
    start[0] = 1'b0;
    flush[0] = 1'b0;
    check("fs_ctl", ctl(0), 32'd0);
    check("fs_drop", e1[0], a);
    run_op(0, 32'h00012345, 32'h00054321);
    lat = lat_of(0);
    a = $urandom;
    b = $urandom;
    start[0] = 1'b1;
    src1[0] = a;
    src2[0] = b;
    @(negedge clk);
    src1[0] = $urandom;
    src2[0] = $urandom;
    for (int c = 1; c <= 2 * lat + 2; c++) begin
      check("b2b_ctl", ctl(0), {29'b0, c <= lat || (c >= lat + 2 && c <= 2 * lat + 1),
                                c == lat || c == 2 * lat + 1, c == 1 || c == lat + 2});
      if (c == lat) check("b2b_r1", result[0], prod(a, b));
      if (c == lat) check("b2b_stable", e1[0], a);
      if (c == 2 * lat + 1) check("b2b_r2", result[0], prod(src1[0], src2[0]));
      if (c == lat + 1) begin
        @(negedge clk);
        start[0] = 1'b0;
      end else if (c <= 2 * lat + 1) @(negedge clk);
    end
    run_op(1, 32'h12345678, 32'h00000010);
    check("r_shift", result[1], 32'h23456780);
    run_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int i = 0; i < 6; i++) run_op(1, $urandom, $urandom);
    start[1] = 1'b1;
    src1[1] = $urandom;
    src2[1] = $urandom;
    @(negedge clk);
    start[1] = 1'b0;
    @(negedge clk);
    check("rw_wait", ctl(1), 32'd4);
    reset_n[1] = 1'b0;
    start[1] = 1'b1;
    flush[1] = 1'b1;
    @(negedge clk);
    reset_n[1] = 1'b1;
    start[1] = 1'b0;
    flush[1] = 1'b0;
    check("rw_res", result[1], 32'd0);
    check("rw_e", e1[1] | e2[1], 32'd0);
    for (int c = 0; c < 6; c++) begin
      check("rw_idle", ctl(1), 32'd0);
      @(negedge clk);
    end
    run_op(1, $urandom, $urandom);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
